r5p_bus_dma: RTL and testbench
==============================

R5P_BUS_DMA -- requirements
Module: r5p_bus_dma

Interface
REQ-001 SHALL have parameter AW, default 22, byte address width.
REQ-002 SHALL have parameter DW, default 32, data width.
REQ-003 SHALL have parameter BW, default DW/8, byte-enable width.
REQ-004 SHALL have parameter LW, default 16, transfer length width in words.
REQ-005 clk  input  1  clock; one clock domain, all logic on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 start  input  1  start request, sampled in IDLE only.
REQ-008 src  input  AW  source byte address, sampled on accepted start.
REQ-009 dst  input  AW  destination byte address, sampled on accepted start.
REQ-010 len  input  LW  word count, sampled on accepted start.
REQ-011 busy  output  1  high while state is not IDLE.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 err  output  1  one-cycle alignment-error pulse, coincident with done.
REQ-014 bus_vld / bus_wen / bus_adr[AW] / bus_ben[BW] / bus_wdt[DW]  output  initiator request on r5p_bus.
REQ-015 bus_rdt  input  DW  read data; bus_rdy  input  1  responder ready.

Function
REQ-016 Bus transfer SHALL occur on a cycle with bus_vld & bus_rdy high.
REQ-017 Once bus_vld is high, bus_wen/adr/ben/wdt SHALL hold stable until transfer.
REQ-018 Read data SHALL be taken from bus_rdt on the cycle after a read transfer (fixed one-cycle latency).
REQ-019 States: IDLE, RD, RDAT, WR.
REQ-020 IDLE: start=1 and len!=0 SHALL latch src/dst/len and go to RD next cycle.
REQ-021 IDLE: start=1 and len=0 SHALL pulse done next cycle; no bus traffic.
REQ-022 RD: bus_vld=1, bus_wen=0, bus_ben all ones, bus_adr=current src; on transfer go to RDAT.
REQ-023 RDAT: bus_vld=0; capture bus_rdt into word buffer; go to WR.
REQ-024 WR: bus_vld=1, bus_wen=1, bus_ben all ones, bus_adr=current dst, bus_wdt=buffer; on transfer decrement count, add BW to src and dst.
REQ-025 WR transfer with count reaching 0 SHALL go to IDLE and pulse done the following cycle; otherwise go to RD.
REQ-026 Address increment SHALL wrap modulo 2^AW.
REQ-027 start while busy SHALL be ignored.
REQ-028 bus_wdt SHALL be driven 0 outside WR; bus_vld=0 in IDLE and RDAT.

Reset
REQ-029 rst SHALL force IDLE, busy=0, done=0, err=0, bus_vld=0, bus_wen=0, bus_adr=0, bus_ben=0, bus_wdt=0, count=0.
REQ-030 rst mid-transfer SHALL abandon it immediately with no done pulse; bus_vld drops on the cycle after rst is sampled.

Configuration
REQ-031 Macro R5P_BUS_DMA_ALIGN_CHK_EN defined: accepted start with src or dst low log2(BW) bits nonzero and len!=0 SHALL pulse done and err next cycle, no bus traffic.
REQ-032 R5P_BUS_DMA_ALIGN_CHK_EN undefined: low log2(BW) bits of src/dst SHALL be forced to 0 at latch; err SHALL be tied 0.

Verification
REQ-033 Copy: src=0x000100, dst=0x200000, len=4, bus_rdy=1 constant -> 4 read + 4 write transfers, write addresses 0x200000..0x20000C, data matches source, done 1 cycle after last write, busy high 12 cycles.
REQ-034 Backpressure: bus_rdy low 3 cycles on each request, len=2 -> request fields stable while waiting, exactly 2 reads + 2 writes, correct data.
REQ-035 Zero length: start with len=0 -> done pulse next cycle, bus_vld never asserted, busy stays 0.
REQ-036 Wrap: src=0x3FFFFC, len=2 (AW=22) -> second read at 0x000000.
REQ-037 Reset mid-copy: rst asserted in WR of word 2 of len=8 -> all outputs at reset values next cycle, no done; new start then completes normally.
REQ-038 Alignment: src=0x000102, len=1 -> with R5P_BUS_DMA_ALIGN_CHK_EN done+err pulse, no traffic; without, read at 0x000100, err=0.

Source files
------------

// File: rtl/r5p_bus_dma.sv
// r5p_bus_dma: single-channel word copy engine (read, buffer, write) on an r5p_bus initiator port.
// Define R5P_BUS_DMA_ALIGN_CHK_EN to reject misaligned src/dst instead of silently aligning them.
module r5p_bus_dma #(
    parameter int AW = 22,
    parameter int DW = 32,
    parameter int BW = DW/8,
    parameter int LW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] src,
    input  logic [AW-1:0] dst,
    input  logic [LW-1:0] len,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          bus_vld,
    output logic          bus_wen,
    output logic [AW-1:0] bus_adr,
    output logic [BW-1:0] bus_ben,
    output logic [DW-1:0] bus_wdt,
    input  logic [DW-1:0] bus_rdt,
    input  logic          bus_rdy
);
    typedef enum logic [1:0] {IDLE, RD, RDAT, WR} state_t;
    localparam logic [AW-1:0] LOW = AW'(BW-1);
    state_t st, st_n;
    logic [AW-1:0] sa, da;
    logic [LW-1:0] cnt;
    logic [DW-1:0] buff;
    logic done_q, err_q, acc, bad, xfer, last;
`ifdef R5P_BUS_DMA_ALIGN_CHK_EN
    assign bad = |((src | dst) & LOW);
`else
    assign bad = 1'b0;
`endif
    assign acc  = (st == IDLE) && start;
    assign xfer = bus_vld && bus_rdy;
    assign last = (st == WR) && xfer && (cnt == LW'(1));
    always_comb begin
        st_n = st;
        case (st)
            IDLE: st_n = (start && len != '0 && !bad) ? RD : IDLE;
            RD:   st_n = xfer ? RDAT : RD;
            RDAT: st_n = WR;
            WR:   st_n = xfer ? (last ? IDLE : RD) : WR;
            default: st_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            st     <= IDLE;
            sa     <= '0;
            da     <= '0;
            cnt    <= '0;
            buff   <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            st     <= st_n;
            done_q <= (acc && (len == '0 || bad)) || last;
            err_q  <= acc && len != '0 && bad;
            // low bits are cleared unconditionally; with the check enabled they are already zero
            if (acc && len != '0 && !bad) begin
                sa  <= src & ~LOW;
                da  <= dst & ~LOW;
                cnt <= len;
            end
            if (st == RDAT) buff <= bus_rdt;
            if (st == WR && xfer) begin
                cnt <= cnt - LW'(1);
                sa  <= sa + AW'(BW);
                da  <= da + AW'(BW);
            end
        end
    end
    assign busy    = st != IDLE;
    assign done    = done_q;
    assign err     = err_q;
    assign bus_vld = (st == RD) || (st == WR);
    assign bus_wen = st == WR;
    assign bus_adr = (st == RD) ? sa : (st == WR) ? da : '0;
    assign bus_ben = bus_vld ? '1 : '0;
    assign bus_wdt = bus_wen ? buff : '0;
endmodule

// File: tb/tb_r5p_bus_dma.sv
// tb_r5p_bus_dma: randomized copy jobs against a transfer-list model of the copy engine.
module tb_r5p_bus_dma;
    logic        clk = 0, rst = 1, start = 0;
    logic [21:0] src = 0, dst = 0;
    logic [15:0] len = 0;
    logic        busy, done, err, bus_vld, bus_wen;
    logic [21:0] bus_adr;
    logic [3:0]  bus_ben;
    logic [31:0] bus_wdt, bus_rdt = 0;
    logic        bus_rdy = 0;
    int npass = 0, ntot = 0;
    logic [21:0] obs_adr [64];
    int busy_cnt, wait_cnt;

    r5p_bus_dma dut (
        .clk(clk), .rst(rst), .start(start), .src(src), .dst(dst), .len(len),
        .busy(busy), .done(done), .err(err),
        .bus_vld(bus_vld), .bus_wen(bus_wen), .bus_adr(bus_adr), .bus_ben(bus_ben),
        .bus_wdt(bus_wdt), .bus_rdt(bus_rdt), .bus_rdy(bus_rdy)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: got running want finished");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    function automatic logic [31:0] mem_val(input logic [21:0] a);
        return ({10'h0, a} * 32'h9E3779B1) ^ 32'hC3A50F1E;
    endfunction

    task automatic chk_idle(input string nm);
        chk({nm, "_busy"}, 32'(busy), 0);
        chk({nm, "_done"}, 32'(done), 0);
        chk({nm, "_err"}, 32'(err), 0);
        chk({nm, "_vld"}, 32'(bus_vld), 0);
        chk({nm, "_wen"}, 32'(bus_wen), 0);
        chk({nm, "_adr"}, 32'(bus_adr), 0);
        chk({nm, "_ben"}, 32'(bus_ben), 0);
        chk({nm, "_wdt"}, bus_wdt, 0);
    endtask

    // Expected behaviour is the list of transfers a word copy must produce, in order.
    task automatic run_job(input logic [21:0] s, input logic [21:0] d, input int n,
                           input int rdy_pct, input int abort_at);
        logic [21:0] ea [$];
        bit          ew [$];
        logic [31:0] ed [$];
        logic [21:0] ra, wa, rd_a;
        bit e, rd_pend, pv;
        int total, ptr, cyc;
`ifdef R5P_BUS_DMA_ALIGN_CHK_EN
        e = n != 0 && ((s | d) & 22'h3) != 0;
`else
        e = 0;
`endif
        for (int i = 0; i < n && !e; i++) begin
            ra = (s & ~22'h3) + 22'(4 * i);
            wa = (d & ~22'h3) + 22'(4 * i);
            ea.push_back(ra); ew.push_back(0); ed.push_back(0);
            ea.push_back(wa); ew.push_back(1); ed.push_back(mem_val(ra));
        end
        total = ea.size();
        ptr = 0; cyc = 0; rd_pend = 0; pv = 0; rd_a = 0;
        busy_cnt = 0; wait_cnt = 0;
        @(negedge clk);
        start = 1; src = s; dst = d; len = 16'(n);
        bus_rdy = $urandom_range(99) < rdy_pct;
        forever begin
            @(negedge clk);
            bus_rdt = rd_pend ? mem_val(rd_a) : $urandom;
            rd_pend = 0;
            if (ptr == total) begin
                start = 0;
                chk("done_pulse", 32'(done), 1);
                chk("done_err", 32'(err), 32'(e));
                chk("done_busy", 32'(busy), 0);
                chk("done_vld", 32'(bus_vld), 0);
                break;
            end
            chk("done_early", 32'(done), 0);
            chk("err_early", 32'(err), 0);
            chk("busy", 32'(busy), 1);
            if (pv) chk("hold_vld", 32'(bus_vld), 1);
            if (bus_vld) begin
                chk("wen", 32'(bus_wen), 32'(ew[ptr]));
                chk("adr", 32'(bus_adr), 32'(ea[ptr]));
                chk("ben", 32'(bus_ben), 32'hF);
            end
            chk("wdt", bus_wdt, (bus_vld && ew[ptr]) ? ed[ptr] : 32'h0);
            busy_cnt++;
            if (ptr == abort_at && bus_vld) begin
                rst = 1; bus_rdy = 0; start = 0;
                @(negedge clk);
                chk_idle("abort");
                rst = 0;
                @(negedge clk);
                chk("abort_nodone", 32'(done), 0);
                return;
            end
            // start while busy must be ignored
            start = 1'($urandom_range(1));
            src = 22'($urandom); dst = 22'($urandom); len = 16'($urandom_range(1, 9));
            bus_rdy = $urandom_range(99) < rdy_pct;
            if (bus_vld && !bus_rdy) wait_cnt++;
            pv = bus_vld && !bus_rdy;
            if (bus_vld && bus_rdy) begin
                obs_adr[ptr] = bus_adr;
                if (!bus_wen) begin rd_pend = 1; rd_a = bus_adr; end
                ptr++;
            end
            if (++cyc > 2000) begin
                start = 0;
                chk("timeout", 0, 1);
                break;
            end
        end
        chk("busy_cycles", 32'(busy_cnt), 32'(3 * (total / 2) + wait_cnt));
        bus_rdy = 0;
        @(negedge clk);
        chk("done_width", 32'(done), 0);
        chk("post_vld", 32'(bus_vld), 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_idle("reset");
        rst = 0;
        run_job(22'h000100, 22'h200000, 4, 100, -1);
        chk("copy_rd0", 32'(obs_adr[0]), 32'h000100);
        chk("copy_wr0", 32'(obs_adr[1]), 32'h200000);
        chk("copy_wr3", 32'(obs_adr[7]), 32'h20000C);
        chk("copy_busy12", 32'(busy_cnt), 12);
        run_job(22'h001000, 22'h300000, 2, 25, -1);
        run_job(22'h000040, 22'h200040, 0, 100, -1);
        chk("zero_busy", 32'(busy_cnt), 0);
        run_job(22'h3FFFFC, 22'h100000, 2, 70, -1);
        chk("wrap_rd1", 32'(obs_adr[2]), 32'h000000);
        chk("wrap_wr1", 32'(obs_adr[3]), 32'h100004);
        run_job(22'h002000, 22'h240000, 8, 80, 3);
        run_job(22'h002000, 22'h240000, 3, 80, -1);
        chk("after_rst_wr2", 32'(obs_adr[5]), 32'h240008);
        run_job(22'h000102, 22'h200000, 1, 100, -1);
`ifndef R5P_BUS_DMA_ALIGN_CHK_EN
        chk("align_rd", 32'(obs_adr[0]), 32'h000100);
`endif
        for (int j = 0; j < 12; j++)
            run_job(22'($urandom_range(22'h1FFF00)), 22'h200000 + 22'($urandom_range(22'h1FFF00)),
                    $urandom_range(0, 6), $urandom_range(40, 100), -1);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
